// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for the NCO tuning port: walks start + k*delta over
// n_points values, holding each for max(dwell,1) cycles, optionally looping.
module nco_sweep_ctrl #(
    parameter int ACC_WIDTH   = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int DWELL_WIDTH = 24
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ACC_WIDTH-1:0]   cfg_start_step,
    input  logic [ACC_WIDTH-1:0]   cfg_delta_step,
    input  logic [COUNT_WIDTH-1:0] cfg_n_points,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_loop,
    input  logic                   start,
    input  logic                   abort,
    output logic [ACC_WIDTH-1:0]   nco_step,
    output logic                   nco_step_enable,
    output logic [COUNT_WIDTH-1:0] point_idx,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DWELL  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] IDX_ONE   = 1;
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = 1;

    logic [1:0]             r_state;
    logic [ACC_WIDTH-1:0]   r_start_step;
    logic [ACC_WIDTH-1:0]   r_delta_step;
    logic [COUNT_WIDTH-1:0] r_n_points;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic                   r_loop;
    logic [ACC_WIDTH-1:0]   r_nco_step;
    logic                   r_step_en;
    logic [COUNT_WIDTH-1:0] r_point_idx;
    logic [DWELL_WIDTH-1:0] r_dwell_cnt;

    logic                   w_capture;
    logic [ACC_WIDTH-1:0]   w_eff_start;
    logic [COUNT_WIDTH-1:0] w_eff_n_points;
    logic [DWELL_WIDTH-1:0] w_eff_dwell;
    logic [DWELL_WIDTH-1:0] w_reload;
    logic                   w_last_point;

    // A config word arriving together with start must take effect for that sweep,
    // so the launch path looks through the shadow registers at the live inputs.
    assign w_capture      = cfg_valid && (r_state == S_IDLE);
    assign w_eff_start    = w_capture ? cfg_start_step : r_start_step;
    assign w_eff_n_points = w_capture ? cfg_n_points   : r_n_points;
    assign w_eff_dwell    = w_capture ? cfg_dwell      : r_dwell;
    assign w_reload       = (w_eff_dwell == '0) ? '0 : (w_eff_dwell - DWELL_ONE);
    assign w_last_point   = (r_point_idx == (r_n_points - IDX_ONE));

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_start_step <= '0;
            r_delta_step <= '0;
            r_n_points   <= '0;
            r_dwell      <= '0;
            r_loop       <= 1'b0;
            r_nco_step   <= '0;
            r_step_en    <= 1'b0;
            r_point_idx  <= '0;
            r_dwell_cnt  <= '0;
        end else begin
            r_step_en <= 1'b0;
            if (w_capture) begin
                r_start_step <= cfg_start_step;
                r_delta_step <= cfg_delta_step;
                r_n_points   <= cfg_n_points;
                r_dwell      <= cfg_dwell;
                r_loop       <= cfg_loop;
            end
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (w_eff_n_points != '0) begin
                            r_state     <= S_DWELL;
                            r_nco_step  <= w_eff_start;
                            r_step_en   <= 1'b1;
                            r_point_idx <= '0;
                            r_dwell_cnt <= w_reload;
                        end else begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_DWELL: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_dwell_cnt != '0) begin
                        r_dwell_cnt <= r_dwell_cnt - DWELL_ONE;
                    end else if (!w_last_point) begin
                        r_nco_step  <= r_nco_step + r_delta_step;
                        r_point_idx <= r_point_idx + IDX_ONE;
                        r_step_en   <= 1'b1;
                        r_dwell_cnt <= w_reload;
                    end else if (r_loop) begin
                        r_nco_step  <= r_start_step;
                        r_point_idx <= '0;
                        r_step_en   <= 1'b1;
                        r_dwell_cnt <= w_reload;
                    end else begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign nco_step        = r_nco_step;
    assign nco_step_enable = r_step_en;
    assign point_idx       = r_point_idx;
    assign busy            = (r_state == S_DWELL);
    assign done            = (r_state == S_FINISH);
    assign cfg_ready       = (r_state == S_IDLE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: a timeline model (point = elapsed/dwell) checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_nco_sweep_ctrl;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_start_step = '0;
    logic [31:0] cfg_delta_step = '0;
    logic [15:0] cfg_n_points = '0;
    logic [23:0] cfg_dwell = '0;
    logic        cfg_loop = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] nco_step;
    logic        nco_step_enable;
    logic [15:0] point_idx;
    logic        busy;
    logic        done;

    always #5 aclk = ~aclk;

    nco_sweep_ctrl dut (
        .aclk            (aclk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_start_step  (cfg_start_step),
        .cfg_delta_step  (cfg_delta_step),
        .cfg_n_points    (cfg_n_points),
        .cfg_dwell       (cfg_dwell),
        .cfg_loop        (cfg_loop),
        .start           (start),
        .abort           (abort),
        .nco_step        (nco_step),
        .nco_step_enable (nco_step_enable),
        .point_idx       (point_idx),
        .busy            (busy),
        .done            (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- timeline model ----------------
    int          cyc = 0;
    bit          m_run = 1'b0;
    int          m_t0 = 0;
    int          m_abort = -1;
    logic [31:0] sh_start = '0, sh_delta = '0;
    int          sh_n = 0, sh_d = 0;
    bit          sh_loop = 1'b0;
    logic [31:0] ru_start = '0, ru_delta = '0;
    int          ru_n = 0, ru_d = 1;
    bit          ru_loop = 1'b0;
    logic [31:0] hold_step = '0;
    int          hold_idx = 0;
    int          ph_m, ph_c;

    // 0 = idle, 1 = sweeping, 2 = done pulse
    function automatic int phase(input int n);
        longint t;
        if (!m_run) return 0;
        if (m_abort >= 0 && n >= m_abort) return 0;
        t = longint'(n) - longint'(m_t0);
        if (t < 0) return 0;
        if (ru_n == 0) return (t == 0) ? 2 : 0;
        if (ru_loop || t < longint'(ru_n) * ru_d) return 1;
        if (t == longint'(ru_n) * ru_d) return 2;
        return 0;
    endfunction

    function automatic int pt(input int n);
        return ((n - m_t0) / ru_d) % ru_n;
    endfunction

    function automatic logic [31:0] pstep(input int n);
        logic [31:0] k;
        k = 32'(pt(n));
        return ru_start + ru_delta * k;
    endfunction

    always @(posedge aclk or posedge rst) begin
        if (rst) begin
            m_run = 1'b0; m_abort = -1;
            sh_start = '0; sh_delta = '0; sh_n = 0; sh_d = 0; sh_loop = 1'b0;
            hold_step = '0; hold_idx = 0;
        end else begin
            ph_m = phase(cyc);
            if (ph_m == 1) begin
                hold_step = pstep(cyc);
                hold_idx  = pt(cyc);
            end
            if (ph_m == 0 && start && !abort) begin
                ru_start = cfg_valid ? cfg_start_step : sh_start;
                ru_delta = cfg_valid ? cfg_delta_step : sh_delta;
                ru_n     = cfg_valid ? int'(cfg_n_points) : sh_n;
                ru_d     = cfg_valid ? int'(cfg_dwell) : sh_d;
                if (ru_d < 1) ru_d = 1;
                ru_loop  = cfg_valid ? cfg_loop : sh_loop;
                m_run = 1'b1; m_t0 = cyc + 1; m_abort = -1;
            end
            if (ph_m != 0 && abort && m_abort < 0) m_abort = cyc + 1;
            if (ph_m == 0 && cfg_valid) begin
                sh_start = cfg_start_step; sh_delta = cfg_delta_step;
                sh_n = int'(cfg_n_points); sh_d = int'(cfg_dwell); sh_loop = cfg_loop;
            end
            cyc++;
        end
    end

    always @(negedge aclk) begin
        if (chk_on) begin
            ph_c = phase(cyc);
            chk("m_busy",  32'(busy),      32'(ph_c == 1));
            chk("m_done",  32'(done),      32'(ph_c == 2));
            chk("m_ready", 32'(cfg_ready), 32'(ph_c == 0));
            chk("m_en",    32'(nco_step_enable),
                32'(ph_c == 1 && ((cyc - m_t0) % ru_d) == 0));
            chk("m_step",  nco_step, (ph_c == 1) ? pstep(cyc) : hold_step);
            chk("m_idx",   32'(point_idx), (ph_c == 1) ? 32'(pt(cyc)) : 32'(hold_idx));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_cfg(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int dw, input bit lp);
        cfg_start_step = s; cfg_delta_step = d;
        cfg_n_points = 16'(n); cfg_dwell = 24'(dw); cfg_loop = lp;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic run_basic(input bit do_cfg, input bit disturb);
        bit e_en;
        if (do_cfg) send_cfg(32'h0040_0000, 32'h0010_0000, 3, 4, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge aclk);
            e_en = (k == 1 || k == 5 || k == 9);
            chk("b_en", 32'(nco_step_enable), 32'(e_en));
            if (e_en) begin
                chk("b_step", nco_step, 32'h0040_0000 + 32'((k - 1) / 4) * 32'h0010_0000);
                chk("b_idx", 32'(point_idx), 32'((k - 1) / 4));
            end
            chk("b_busy", 32'(busy), 32'(k <= 12));
            chk("b_done", 32'(done), 32'(k == 13));
            if (k == 14) chk("b_ready", 32'(cfg_ready), 32'd1);
            if (disturb && k == 3) begin
                start = 1'b1;
                cfg_valid = 1'b1;
                cfg_start_step = 32'h1234_5678;
                cfg_n_points = 16'd5;
                cfg_dwell = 24'd1;
            end
            tick();
            start = 1'b0;
            cfg_valid = 1'b0;
        end
    endtask

    initial begin
        tick();
        tick();
        @(negedge aclk);
        chk("rst_step",  nco_step, 32'h0);
        chk("rst_en",    32'(nco_step_enable), 32'd0);
        chk("rst_idx",   32'(point_idx), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // basic sweep
        run_basic(1'b1, 1'b0);
        tick();

        // loop mode, aborted in cycle 15
        send_cfg(32'h0040_0000, 32'h0010_0000, 3, 4, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge aclk);
            chk("l_done", 32'(done), 32'd0);
            if (k == 13) begin
                chk("l_en", 32'(nco_step_enable), 32'd1);
                chk("l_step", nco_step, 32'h0040_0000);
                chk("l_idx", 32'(point_idx), 32'd0);
            end
            if (k == 15) begin
                chk("l_busy15", 32'(busy), 32'd1);
                abort = 1'b1;
            end
            if (k == 16) begin
                chk("l_busy16", 32'(busy), 32'd0);
                chk("l_hold", nco_step, 32'h0040_0000);
            end
            tick();
            abort = 1'b0;
        end
        tick();

        // wrap with negative delta, dwell 0
        send_cfg(32'h0000_0000, 32'hFFF0_0000, 2, 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge aclk);
            chk("w_en", 32'(nco_step_enable), 32'(k <= 2));
            if (k == 1) chk("w_step1", nco_step, 32'h0000_0000);
            if (k == 2) begin
                chk("w_step2", nco_step, 32'hFFF0_0000);
                chk("w_idx2", 32'(point_idx), 32'd1);
            end
            chk("w_done", 32'(done), 32'(k == 3));
            tick();
        end

        // n_points = 0: config in cycle 0, start in cycle 1
        send_cfg(32'h0000_1000, 32'h0000_0010, 0, 5, 1'b0);
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge aclk);
            chk("z_done", 32'(done), 32'(k == 2));
            chk("z_en", 32'(nco_step_enable), 32'd0);
            chk("z_step", nco_step, 32'hFFF0_0000);
            tick();
            start = 1'b0;
        end

        // start and abort together
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("sa_busy", 32'(busy), 32'd0);
            chk("sa_done", 32'(done), 32'd0);
            tick();
        end

        // start and cfg_valid while busy, then rerun from the untouched shadow
        run_basic(1'b1, 1'b1);
        tick();
        run_basic(1'b0, 1'b0);
        tick();

        // async reset mid-dwell
        send_cfg(32'h0040_0000, 32'h0010_0000, 3, 4, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("ar_step",  nco_step, 32'h0);
        chk("ar_busy",  32'(busy), 32'd0);
        chk("ar_ready", 32'(cfg_ready), 32'd1);
        chk("ar_en",    32'(nco_step_enable), 32'd0);
        chk("ar_idx",   32'(point_idx), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_basic(1'b1, 1'b0);
        tick();
        tick();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer that drives the NCO tuning interface (nco_step / nco_step_enable) of the DSM transmit chain. It steps the tone through a programmed list of frequency points: start step, signed increment, point count and dwell time per point, with optional continuous looping. Software or a test controller programs it through a valid/ready config port. The outputs connect directly to the dsm_model / NCO step inputs in the aclk domain.

Parameters:
ACC_WIDTH, 32, NCO phase-step width (8 integer + 24 fractional bits)
COUNT_WIDTH, 16, width of point count and point index
DWELL_WIDTH, 24, width of the dwell-cycle counter

Ports:
aclk  in  1  system clock; all logic is on the rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config word valid
cfg_ready  out  1  config accepted; high only in IDLE
cfg_start_step  in  ACC_WIDTH  first step value
cfg_delta_step  in  ACC_WIDTH  signed two's-complement increment per point
cfg_n_points  in  COUNT_WIDTH  number of points per sweep
cfg_dwell  in  DWELL_WIDTH  aclk cycles held per point; 0 is treated as 1
cfg_loop  in  1  1 = restart the sweep after the last point
start  in  1  single-cycle start request
abort  in  1  single-cycle stop request
nco_step  out  ACC_WIDTH  step value to the NCO
nco_step_enable  out  1  one-cycle load strobe for nco_step
point_idx  out  COUNT_WIDTH  index of the current point
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at normal sweep completion

Behaviour:
- Reset (async assert, sync release): state IDLE. All of the following are 0: nco_step, nco_step_enable, point_idx, busy, done, and the config shadow registers. cfg_ready is 1.
- States: IDLE, DWELL, FINISH.
- Config capture: cfg_valid && cfg_ready latches all cfg_* fields into shadow registers. Inputs are ignored outside IDLE.
- Same-cycle cfg_valid and start in IDLE: the newly captured config is used.
- IDLE -> DWELL on start when shadow n_points != 0. In the next cycle:
  - nco_step = start_step, nco_step_enable = 1, point_idx = 0, busy = 1
  - dwell counter loaded with max(dwell,1) - 1
- IDLE -> FINISH on start when n_points == 0. No step change; done pulses the next cycle.
- DWELL, counter != 0: decrement. nco_step is held and nco_step_enable = 0.
- DWELL, counter == 0, point_idx < n_points - 1:
  - nco_step += delta_step, modulo 2^ACC_WIDTH (wrap, no saturation)
  - point_idx++, enable strobe, counter reloaded
- DWELL, counter == 0, last point:
  - cfg_loop = 1: nco_step = start_step, point_idx = 0, strobe, counter reloaded. There is no gap cycle and done does not pulse.
  - cfg_loop = 0: go to FINISH.
- FINISH (one cycle): done = 1, busy = 0, then return to IDLE.
- Each point is therefore held for exactly max(dwell,1) cycles, counted from its strobe.
- nco_step holds its last value in IDLE and FINISH.
- abort (DWELL or FINISH): go to IDLE the next cycle. busy = 0, no done pulse, nco_step holds, point_idx holds.
- abort and start in the same cycle: abort wins and the sweep does not start.
- start while busy: ignored.
- nco_step_enable is never high for two consecutive cycles unless dwell <= 1. With dwell <= 1 it is high every cycle of the sweep.
- Reset asserted mid-sweep: outputs go to their reset values immediately, regardless of aclk.

Test Plan:
- Basic sweep: cfg start = 0x0040_0000, delta = 0x0010_0000, n_points = 3, dwell = 4, loop = 0; start in cycle 0.
  - Strobes in cycles 1, 5 and 9 with nco_step = 0x0040_0000, 0x0050_0000, 0x0060_0000 and point_idx = 0, 1, 2.
  - busy is high for cycles 1-12; done = 1 and busy = 0 in cycle 13; cfg_ready = 1 in cycle 14.
- Loop mode: same config with loop = 1.
  - Cycle 13 strobes nco_step = 0x0040_0000 with point_idx = 0; done never asserts.
  - An abort in cycle 15 gives busy = 0 in cycle 16 with nco_step still 0x0040_0000.
- Wrap and negative delta: start = 0x0000_0000, delta = 0xFFF0_0000 (-2^20), n_points = 2, dwell = 0.
  - Strobes in cycles 1 and 2 with nco_step = 0x0000_0000 then 0xFFF0_0000.
  - done in cycle 3.
- Edge requests:
  - n_points = 0: start gives no strobe, done in cycle 2 only.
  - start and abort in the same cycle: busy stays 0.
  - start while busy: no effect on the sequence.
  - cfg_valid while busy: the shadow registers are unchanged.
- Async reset: assert rst mid-dwell between clock edges.
  - nco_step = 0, busy = 0 and cfg_ready = 1 before the next aclk edge.
  - A fresh cfg followed by start after release produces the basic-sweep timing.
